// File: rtl/mem_arb_if.sv
// Port bundle for the two-requester memory arbiter: fetch, load/store and memory-side signals.
// The arbiter connects through the slave modport; the requesters and memory model use master.
interface mem_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  i_if_req;
  logic [ADDR_W-1:0]     i_if_addr;
  logic                  i_if_flush;
  logic                  o_if_gnt;
  logic                  o_if_rvalid;
  logic [DATA_W-1:0]     o_if_rdata;

  logic                  i_ls_req;
  logic                  i_ls_we;
  logic [ADDR_W-1:0]     i_ls_addr;
  logic [DATA_W-1:0]     i_ls_wdata;
  logic [DATA_W/8-1:0]   i_ls_be;
  logic                  o_ls_gnt;
  logic                  o_ls_rvalid;
  logic [DATA_W-1:0]     o_ls_rdata;

  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [DATA_W-1:0]     o_mem_wdata;
  logic [DATA_W/8-1:0]   o_mem_be;
  logic                  i_mem_ack;
  logic [DATA_W-1:0]     i_mem_rdata;

  logic                  o_stall_if;
  logic                  o_stall_ls;

  modport slave (
    input  i_if_req, i_if_addr, i_if_flush,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_be,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_ack, i_mem_rdata,
    output o_stall_if, o_stall_ls
  );

  modport master (
    output i_if_req, i_if_addr, i_if_flush,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_be,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_ack, i_mem_rdata,
    input  o_stall_if, o_stall_ls
  );
endinterface

// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch and load/store, LS-priority with
// a starvation counter that lets fetch win once after STARVE_MAX consecutive losses.
module mem_arb #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mem_arb_if.slave    bus_io
);

  localparam int unsigned BeW = DATA_W / 8;

  typedef enum logic {StIdle, StWait} state_e;

  state_e              state_q;
  logic                owner_ls_q;
  logic                drop_q;
  logic [3:0]          starve_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BeW-1:0]      mem_be_q;
  logic                if_rvalid_q;
  logic                ls_rvalid_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   ls_rdata_q;

  logic if_ok;
  logic starved;
  logic gnt_if;
  logic gnt_ls;
  logic ls_store;

  always_comb begin
    if_ok    = bus_io.i_if_req & ~bus_io.i_if_flush;
    starved  = (starve_q == 4'(STARVE_MAX));
    ls_store = bus_io.i_ls_we;
    gnt_if   = 1'b0;
    gnt_ls   = 1'b0;
    if (!i_rst && state_q == StIdle) begin
      if (if_ok && (!bus_io.i_ls_req || starved)) begin
        gnt_if = 1'b1;
      end else if (bus_io.i_ls_req) begin
        gnt_ls = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      owner_ls_q  <= 1'b0;
      drop_q      <= 1'b0;
      starve_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (gnt_if || gnt_ls) begin
            state_q     <= StWait;
            owner_ls_q  <= gnt_ls;
            mem_req_q   <= 1'b1;
            mem_we_q    <= gnt_ls & ls_store;
            mem_addr_q  <= gnt_ls ? bus_io.i_ls_addr : bus_io.i_if_addr;
            mem_wdata_q <= (gnt_ls && ls_store) ? bus_io.i_ls_wdata : '0;
            mem_be_q    <= (gnt_ls && ls_store) ? bus_io.i_ls_be : '1;
            // Only an unflushed fetch that lost counts as starvation.
            if (gnt_if) begin
              starve_q <= 4'd0;
            end else if (if_ok && starve_q < 4'(STARVE_MAX)) begin
              starve_q <= starve_q + 4'd1;
            end
          end
        end
        StWait: begin
          if (!owner_ls_q && bus_io.i_if_flush) begin
            drop_q <= 1'b1;
          end
          if (bus_io.i_mem_ack) begin
            state_q     <= StIdle;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if (owner_ls_q) begin
              ls_rvalid_q <= 1'b1;
              ls_rdata_q  <= mem_we_q ? '0 : bus_io.i_mem_rdata;
            end else if (!(drop_q || bus_io.i_if_flush)) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus_io.i_mem_rdata;
            end
          end
        end
      endcase
    end
  end

  assign bus_io.o_if_gnt    = gnt_if;
  assign bus_io.o_ls_gnt    = gnt_ls;
  assign bus_io.o_if_rvalid = if_rvalid_q;
  assign bus_io.o_ls_rvalid = ls_rvalid_q;
  assign bus_io.o_if_rdata  = if_rdata_q;
  assign bus_io.o_ls_rdata  = ls_rdata_q;
  assign bus_io.o_mem_req   = mem_req_q;
  assign bus_io.o_mem_we    = mem_we_q;
  assign bus_io.o_mem_addr  = mem_addr_q;
  assign bus_io.o_mem_wdata = mem_wdata_q;
  assign bus_io.o_mem_be    = mem_be_q;
  assign bus_io.o_stall_if  = bus_io.i_if_req & ~if_rvalid_q;
  assign bus_io.o_stall_ls  = bus_io.i_ls_req & ~ls_rvalid_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arb;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an outstanding access (if any) plus delivered results.
  bit              m_busy, m_own_ls, m_drop, m_we, m_if_rv, m_ls_rv;
  int              m_starve;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata, m_if_rd, m_ls_rd;
  logic [3:0]      m_be;
  bit              e_gif, e_gls, flush_now;

  initial begin
    m_busy = 0; m_own_ls = 0; m_drop = 0; m_we = 0; m_if_rv = 0; m_ls_rv = 0;
    m_starve = 0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_ls_rd = '0; m_be = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      flush_now = bus.i_if_flush;
      e_gif = 0;
      e_gls = 0;
      if (!rst && !m_busy) begin
        if (bus.i_if_req && !flush_now && (!bus.i_ls_req || m_starve == SM)) e_gif = 1;
        else if (bus.i_ls_req) e_gls = 1;
      end
      chk("m_if_gnt",    bus.o_if_gnt,    e_gif);
      chk("m_ls_gnt",    bus.o_ls_gnt,    e_gls);
      chk("m_mem_req",   bus.o_mem_req,   m_busy);
      chk("m_mem_we",    bus.o_mem_we,    m_we);
      chk("m_mem_addr",  bus.o_mem_addr,  m_addr);
      chk("m_mem_wdata", bus.o_mem_wdata, m_wdata);
      chk("m_mem_be",    bus.o_mem_be,    m_be);
      chk("m_if_rvalid", bus.o_if_rvalid, m_if_rv);
      chk("m_ls_rvalid", bus.o_ls_rvalid, m_ls_rv);
      chk("m_if_rdata",  bus.o_if_rdata,  m_if_rd);
      chk("m_ls_rdata",  bus.o_ls_rdata,  m_ls_rd);
      chk("m_stall_if",  bus.o_stall_if,  bus.i_if_req && !m_if_rv);
      chk("m_stall_ls",  bus.o_stall_ls,  bus.i_ls_req && !m_ls_rv);
      if (rst) begin
        m_busy = 0; m_own_ls = 0; m_drop = 0; m_we = 0; m_if_rv = 0; m_ls_rv = 0;
        m_starve = 0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_ls_rd = '0; m_be = '0;
      end else begin
        m_if_rv = 0;
        m_ls_rv = 0;
        if (m_busy) begin
          if (!m_own_ls && flush_now) m_drop = 1;
          if (bus.i_mem_ack) begin
            if (m_own_ls) begin
              m_ls_rv = 1;
              m_ls_rd = m_we ? '0 : bus.i_mem_rdata;
            end else if (!m_drop) begin
              m_if_rv = 1;
              m_if_rd = bus.i_mem_rdata;
            end
            m_busy = 0; m_drop = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
          end
        end else if (e_gif || e_gls) begin
          m_busy   = 1;
          m_own_ls = e_gls;
          m_we     = e_gls && bus.i_ls_we;
          m_addr   = e_gls ? bus.i_ls_addr : bus.i_if_addr;
          m_wdata  = m_we ? bus.i_ls_wdata : '0;
          m_be     = m_we ? bus.i_ls_be : 4'hF;
          if (e_gif) m_starve = 0;
          else if (bus.i_if_req && !flush_now) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_if_req = 0; bus.i_if_addr = '0; bus.i_if_flush = 0;
    bus.i_ls_req = 0; bus.i_ls_we = 0; bus.i_ls_addr = '0; bus.i_ls_wdata = '0;
    bus.i_ls_be = '0; bus.i_mem_ack = 0; bus.i_mem_rdata = '0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1;
    clear_inputs();
    cyc();
    rst = 0;
  endtask

  int  ng;
  bit  seq [10];
  bit  prev_flush;

  initial begin
    rst = 1;
    clear_inputs();
    bus.i_if_req = 1;
    bus.i_ls_req = 1;
    cyc();
    look();
    chk("rst_if_gnt", bus.o_if_gnt, 0);
    chk("rst_ls_gnt", bus.o_ls_gnt, 0);
    chk("rst_stall_if", bus.o_stall_if, 1);
    chk("rst_mem_req", bus.o_mem_req, 0);
    chk("rst_if_rdata", bus.o_if_rdata, 0);
    chk("rst_ls_rvalid", bus.o_ls_rvalid, 0);
    cyc();
    clear_inputs();
    rst = 0;

    // IF-only read
    cyc();
    bus.i_if_req = 1; bus.i_if_addr = 32'h100;
    look(); chk("d22_gnt", bus.o_if_gnt, 1);
    cyc(); look();
    chk("d22_req1", bus.o_mem_req, 1);
    chk("d22_addr", bus.o_mem_addr, 32'h100);
    chk("d22_be", bus.o_mem_be, 4'hF);
    chk("d22_we", bus.o_mem_we, 0);
    cyc(); bus.i_mem_ack = 1; bus.i_mem_rdata = 32'hDEADBEEF;
    look(); chk("d22_req2", bus.o_mem_req, 1);
    cyc(); bus.i_mem_ack = 0; bus.i_if_req = 0;
    look();
    chk("d22_rvalid", bus.o_if_rvalid, 1);
    chk("d22_rdata", bus.o_if_rdata, 32'hDEADBEEF);
    chk("d22_req_off", bus.o_mem_req, 0);
    cyc(); look();
    chk("d22_rvalid_pulse", bus.o_if_rvalid, 0);
    chk("d22_rdata_hold", bus.o_if_rdata, 32'hDEADBEEF);

    // Contention with both requests held
    do_reset();
    bus.i_if_req = 1; bus.i_if_addr = 32'h200;
    bus.i_ls_req = 1; bus.i_ls_we = 0; bus.i_ls_addr = 32'h400;
    ng = 0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      look();
      chk("d23_excl", bus.o_if_gnt && bus.o_ls_gnt, 0);
      if (bus.o_if_gnt || bus.o_ls_gnt) begin
        seq[ng] = bus.o_if_gnt;
        ng++;
      end
      cyc();
      bus.i_mem_ack = bus.o_mem_req;
    end
    chk("d23_count", ng, 10);
    for (int k = 0; k < ng; k++) chk("d23_order", seq[k], (k % 5) == 4);
    clear_inputs();

    // Ack withheld for ten cycles on a load
    do_reset();
    bus.i_ls_req = 1; bus.i_ls_we = 0; bus.i_ls_addr = 32'h80;
    look(); chk("d27_gnt", bus.o_ls_gnt, 1);
    for (int c = 0; c < 10; c++) begin
      cyc();
      bus.i_if_req = 1; bus.i_if_addr = 32'h500;
      look();
      chk("d27_req", bus.o_mem_req, 1);
      chk("d27_addr", bus.o_mem_addr, 32'h80);
      chk("d27_no_gnt", bus.o_if_gnt || bus.o_ls_gnt, 0);
      chk("d27_stall_ls", bus.o_stall_ls, 1);
    end
    cyc(); bus.i_mem_ack = 1; bus.i_mem_rdata = 32'hCAFEF00D;
    look();
    cyc(); bus.i_mem_ack = 0; bus.i_ls_req = 0; bus.i_if_req = 0;
    look();
    chk("d27_rvalid", bus.o_ls_rvalid, 1);
    chk("d27_rdata", bus.o_ls_rdata, 32'hCAFEF00D);

    // Store following the load: rdata must be forced to zero
    cyc();
    bus.i_ls_req = 1; bus.i_ls_we = 1; bus.i_ls_addr = 32'h2004;
    bus.i_ls_wdata = 32'h12345678; bus.i_ls_be = 4'b0011; bus.i_mem_rdata = 32'hFFFFFFFF;
    look(); chk("d24_gnt", bus.o_ls_gnt, 1);
    for (int c = 0; c < 2; c++) begin
      cyc(); look();
      chk("d24_we", bus.o_mem_we, 1);
      chk("d24_be", bus.o_mem_be, 4'b0011);
      chk("d24_addr", bus.o_mem_addr, 32'h2004);
      chk("d24_wdata", bus.o_mem_wdata, 32'h12345678);
    end
    cyc(); bus.i_mem_ack = 1;
    look(); chk("d24_req", bus.o_mem_req, 1);
    cyc(); bus.i_mem_ack = 0; bus.i_ls_req = 0;
    look();
    chk("d24_rvalid", bus.o_ls_rvalid, 1);
    chk("d24_rdata", bus.o_ls_rdata, 0);

    // Flush during an IF access
    do_reset();
    bus.i_if_req = 1; bus.i_if_addr = 32'h300;
    look(); chk("d25_gnt", bus.o_if_gnt, 1);
    cyc(); bus.i_if_flush = 1;
    look(); chk("d25_req", bus.o_mem_req, 1);
    cyc(); bus.i_if_flush = 0; bus.i_if_req = 0;
    cyc();
    cyc(); bus.i_mem_ack = 1; bus.i_mem_rdata = 32'h11111111;
    look();
    cyc(); bus.i_mem_ack = 0; bus.i_if_req = 1; bus.i_if_addr = 32'h304;
    look();
    chk("d25_no_rvalid", bus.o_if_rvalid, 0);
    chk("d25_rdata", bus.o_if_rdata, 0);
    chk("d25_regnt", bus.o_if_gnt, 1);
    cyc(); look(); chk("d25_addr2", bus.o_mem_addr, 32'h304);
    cyc(); bus.i_mem_ack = 1; bus.i_mem_rdata = 32'h22222222;
    cyc(); bus.i_mem_ack = 0; bus.i_if_req = 0;
    look();
    chk("d25_rvalid2", bus.o_if_rvalid, 1);
    chk("d25_rdata2", bus.o_if_rdata, 32'h22222222);

    // Reset in the middle of a load
    do_reset();
    bus.i_ls_req = 1; bus.i_ls_addr = 32'h40;
    look(); chk("d26_gnt", bus.o_ls_gnt, 1);
    cyc(); rst = 1; bus.i_ls_req = 0; bus.i_if_req = 1;
    look();
    chk("d26_rst_gnt", bus.o_if_gnt, 0);
    chk("d26_rst_stall", bus.o_stall_if, 1);
    cyc(); rst = 0; bus.i_if_req = 0; bus.i_mem_ack = 1; bus.i_mem_rdata = 32'h33333333;
    look();
    chk("d26_req", bus.o_mem_req, 0);
    chk("d26_addr", bus.o_mem_addr, 0);
    cyc(); bus.i_mem_ack = 0;
    look();
    chk("d26_rvalid", bus.o_ls_rvalid, 0);
    chk("d26_rdata", bus.o_ls_rdata, 0);

    // Randomized traffic under protocol-respecting requesters
    prev_flush = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rst = ($urandom_range(0, 299) == 0);
      if (rst) begin
        bus.i_if_req = 0; bus.i_ls_req = 0; bus.i_if_flush = 0;
      end else begin
        prev_flush = bus.i_if_flush;
        if (prev_flush) begin
          bus.i_if_req = 0;
        end else if (bus.o_if_rvalid || !bus.i_if_req) begin
          bus.i_if_req  = ($urandom_range(0, 2) != 0);
          bus.i_if_addr = $urandom & 32'hFFFF_FFFC;
        end
        bus.i_if_flush = ($urandom_range(0, 15) == 0);
        if (bus.o_ls_rvalid || !bus.i_ls_req) begin
          bus.i_ls_req   = ($urandom_range(0, 2) != 0);
          bus.i_ls_we    = $urandom_range(0, 1);
          bus.i_ls_addr  = $urandom & 32'hFFFF_FFFC;
          bus.i_ls_wdata = $urandom;
          bus.i_ls_be    = 4'($urandom_range(1, 15));
        end
      end
      bus.i_mem_ack   = ($urandom_range(0, 2) == 0);
      bus.i_mem_rdata = $urandom;
    end
    cyc();
    clear_inputs();
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
